// File: rtl/rx_pkg.sv
// Shared definitions for the receive-chain sequencer: datapath widths and
// the sequencer state encoding seen on o_state.
package rx_pkg;
  localparam int RX_TIME_W = 16;
  localparam int RX_CORR_W = 41;
  localparam int RX_SEQ_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_ARMED   = 2'd2,
    ST_HOLDOFF = 2'd3
  } rx_state_t;
endpackage

// File: rtl/rx_strobe_gen.sv
// Sample-period counter producing the one-in-PERIOD strobe and the
// free-running sample timestamp for the receive chain.
module rx_strobe_gen
  import rx_pkg::*;
#(
  parameter int PERIOD = 128,
  parameter int TIME_W = RX_TIME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              run,
  input  logic              clear,
  output logic              tick,
  output logic              strobe,
  output logic [TIME_W-1:0] cur_time
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;
  logic          strobe_q;

  // tick marks the edge on which a new sample begins; the strobe register
  // makes it visible one cycle later, together with the incremented time.
  assign tick   = enable && run && !clear && (count == LAST);
  assign strobe = strobe_q && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      strobe_q <= 1'b0;
      cur_time <= '0;
    end else if (enable) begin
      if (clear) begin
        count    <= '0;
        strobe_q <= 1'b0;
        cur_time <= '0;
      end else if (run) begin
        strobe_q <= tick;
        if (count == LAST) begin
          count    <= '0;
          cur_time <= cur_time + 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        strobe_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rx_sequencer.sv
// Receive-chain control: start-up sequencing (warm-up, armed, hold-off),
// sample timing, and the detection register read by the ARM.
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int SAMPLE_PERIOD   = 128,
  parameter int WARMUP_SAMPLES  = 64,
  parameter int HOLDOFF_SAMPLES = 256
) (
  input  logic                 crx_clk,
  input  logic                 rrx_rst,
  input  logic                 erx_en,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_peak_trigger,
  input  logic [RX_CORR_W-1:0] i_peak_value,
  input  logic [RX_SEQ_W-1:0]  i_peak_seq,
  input  logic                 i_arm_ack,
  output logic                 o_sample_strobe,
  output logic                 o_chain_en,
  output logic [RX_TIME_W-1:0] o_current_time,
  output logic                 o_det_valid,
  output logic [RX_CORR_W-1:0] o_det_value,
  output logic [RX_SEQ_W-1:0]  o_det_seq,
  output logic [RX_TIME_W-1:0] o_det_time,
  output logic                 o_overrun,
  output logic [1:0]           o_state
);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_SAMPLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_SAMPLES - 1);

  rx_state_t   state;
  logic [15:0] phase_count;
  logic        tick;
  logic        start_acc;
  logic        armed_trig;

  assign start_acc  = (state == ST_IDLE) && i_start && !i_stop;
  assign armed_trig = (state == ST_ARMED) && i_peak_trigger;
  assign o_state    = state;

  rx_strobe_gen #(
    .PERIOD(SAMPLE_PERIOD),
    .TIME_W(RX_TIME_W)
  ) u_strobe_gen (
    .clk     (crx_clk),
    .rst     (rrx_rst),
    .enable  (erx_en),
    .run     (state != ST_IDLE),
    .clear   (start_acc),
    .tick    (tick),
    .strobe  (o_sample_strobe),
    .cur_time(o_current_time)
  );

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state       <= ST_IDLE;
      phase_count <= '0;
      o_chain_en  <= 1'b0;
      o_det_valid <= 1'b0;
      o_det_value <= '0;
      o_det_seq   <= '0;
      o_det_time  <= '0;
      o_overrun   <= 1'b0;
    end else if (erx_en) begin
      // An ack in the capture cycle frees the register for the new detection.
      if (armed_trig && (!o_det_valid || i_arm_ack)) begin
        o_det_valid <= 1'b1;
        o_det_value <= i_peak_value;
        o_det_seq   <= i_peak_seq;
        o_det_time  <= o_current_time;
      end else if (armed_trig) begin
        o_overrun <= 1'b1;
      end else if (i_arm_ack) begin
        o_det_valid <= 1'b0;
      end
      if (start_acc) begin
        o_overrun <= 1'b0;
      end

      if (i_stop) begin
        state      <= ST_IDLE;
        o_chain_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_acc) begin
              state       <= ST_WARMUP;
              phase_count <= '0;
              o_chain_en  <= 1'b1;
            end
          end
          ST_WARMUP: begin
            if (tick) begin
              if (phase_count == WARM_LAST) begin
                state       <= ST_ARMED;
                phase_count <= '0;
              end else begin
                phase_count <= phase_count + 1'b1;
              end
            end
          end
          ST_ARMED: begin
            if (i_peak_trigger) begin
              state       <= ST_HOLDOFF;
              phase_count <= '0;
            end
          end
          ST_HOLDOFF: begin
            if (tick) begin
              if (phase_count == HOLD_LAST) begin
                state       <= ST_ARMED;
                phase_count <= '0;
              end else begin
                phase_count <= phase_count + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_sequencer.sv
// Bench for rx_sequencer: directed start-up/capture scenarios plus random
// traffic, all compared every cycle against a sample-level reference model.
module tb_rx_sequencer;
  localparam int P = 8;
  localparam int W = 4;
  localparam int H = 3;

  logic        crx_clk = 1'b0;
  logic        rrx_rst, erx_en, i_start, i_stop, i_peak_trigger, i_arm_ack;
  logic [40:0] i_peak_value;
  logic [3:0]  i_peak_seq;
  logic        o_sample_strobe, o_chain_en, o_det_valid, o_overrun;
  logic [15:0] o_current_time, o_det_time;
  logic [40:0] o_det_value;
  logic [3:0]  o_det_seq;
  logic [1:0]  o_state;

  logic        wrap_run, wrap_clear, wrap_tick, wrap_strobe;
  logic [7:0]  wrap_time;

  always #5 crx_clk = ~crx_clk;

  rx_sequencer #(.SAMPLE_PERIOD(P), .WARMUP_SAMPLES(W), .HOLDOFF_SAMPLES(H)) dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
    .i_start(i_start), .i_stop(i_stop), .i_peak_trigger(i_peak_trigger),
    .i_peak_value(i_peak_value), .i_peak_seq(i_peak_seq), .i_arm_ack(i_arm_ack),
    .o_sample_strobe(o_sample_strobe), .o_chain_en(o_chain_en),
    .o_current_time(o_current_time), .o_det_valid(o_det_valid),
    .o_det_value(o_det_value), .o_det_seq(o_det_seq), .o_det_time(o_det_time),
    .o_overrun(o_overrun), .o_state(o_state)
  );

  // A narrow timestamp lets the wrap-around be reached in a few hundred clocks.
  rx_strobe_gen #(.PERIOD(2), .TIME_W(8)) u_wrap (
    .clk(crx_clk), .rst(rrx_rst), .enable(1'b1), .run(wrap_run), .clear(wrap_clear),
    .tick(wrap_tick), .strobe(wrap_strobe), .cur_time(wrap_time)
  );

  int          check_count = 0;
  int          error_count = 0;
  int          m_state, m_clocks, m_samples;
  bit          m_strobe, m_valid, m_overrun;
  logic [40:0] m_value;
  logic [3:0]  m_seq;
  logic [15:0] m_time, m_det_time;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: count running clocks since start; every P-th one is a new sample.
  task automatic modelStep();
    bit running, sample, start_ok, armed_hit;
    if (rrx_rst) begin
      m_state = 0; m_clocks = 0; m_samples = 0; m_strobe = 0; m_time = 0;
      m_valid = 0; m_value = 0; m_seq = 0; m_det_time = 0; m_overrun = 0;
    end else if (erx_en) begin
      running   = (m_state != 0);
      sample    = running && (((m_clocks + 1) % P) == 0);
      start_ok  = (m_state == 0) && i_start && !i_stop;
      armed_hit = (m_state == 2) && i_peak_trigger;
      if (armed_hit) begin
        if (!m_valid || i_arm_ack) begin
          m_valid = 1; m_value = i_peak_value; m_seq = i_peak_seq; m_det_time = m_time;
        end else begin
          m_overrun = 1;
        end
      end else if (i_arm_ack) begin
        m_valid = 0;
      end
      if (start_ok) begin
        m_overrun = 0; m_clocks = 0; m_time = 0;
      end else if (running) begin
        m_clocks++;
        if (sample) m_time = m_time + 16'd1;
      end
      m_strobe = sample;
      if (i_stop) m_state = 0;
      else if (m_state == 0 && i_start) begin m_state = 1; m_samples = 0; end
      else if (m_state == 2 && i_peak_trigger) begin m_state = 3; m_samples = 0; end
      else if ((m_state == 1 || m_state == 3) && sample) begin
        m_samples++;
        if (m_samples == ((m_state == 1) ? W : H)) begin m_state = 2; m_samples = 0; end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("state", 64'(o_state), 64'(m_state));
    checkOutput("chain_en", 64'(o_chain_en), 64'(m_state != 0));
    checkOutput("strobe", 64'(o_sample_strobe), 64'(m_strobe && erx_en));
    checkOutput("time", 64'(o_current_time), 64'(m_time));
    checkOutput("det_valid", 64'(o_det_valid), 64'(m_valid));
    checkOutput("det_value", 64'(o_det_value), 64'(m_value));
    checkOutput("det_seq", 64'(o_det_seq), 64'(m_seq));
    checkOutput("det_time", 64'(o_det_time), 64'(m_det_time));
    checkOutput("overrun", 64'(o_overrun), 64'(m_overrun));
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit start, input bit stop,
                               input bit trig, input bit ack, input logic [40:0] value,
                               input logic [3:0] seq);
    rrx_rst = rst; erx_en = en; i_start = start; i_stop = stop;
    i_peak_trigger = trig; i_arm_ack = ack; i_peak_value = value; i_peak_seq = seq;
    @(posedge crx_clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic stepIdle();
    applyStimulus(0, 1, 0, 0, 0, 0, 41'd0, 4'd0);
  endtask

  task automatic waitArmed(input string tag, output int strobes);
    int n;
    n = 0;
    strobes = 0;
    while (o_state != 2'd2 && n < 200) begin
      stepIdle();
      n++;
      if (o_sample_strobe) strobes++;
    end
    checkOutput({tag, "_reached"}, 64'(o_state), 64'd2);
  endtask

  initial begin
    int strobes, first_strobe, wrap_count, n;
    wrap_run = 0; wrap_clear = 0;
    applyStimulus(1, 1, 0, 0, 0, 0, 41'd0, 4'd0);
    applyStimulus(1, 0, 1, 0, 1, 1, 41'd3, 4'd3);
    checkOutput("reset_state", 64'(o_state), 64'd0);
    checkOutput("reset_time", 64'(o_current_time), 64'd0);
    checkOutput("wrap_tick_idle", 64'(wrap_tick), 64'd0);

    applyStimulus(0, 1, 1, 0, 0, 0, 41'd0, 4'd0);
    for (int c = 1; c <= 32; c++) begin
      stepIdle();
      checkOutput("t1_strobe", 64'(o_sample_strobe), 64'(c % 8 == 0));
    end
    checkOutput("t1_armed", 64'(o_state), 64'd2);
    checkOutput("t1_time", 64'(o_current_time), 64'd4);

    applyStimulus(0, 1, 0, 0, 1, 0, -41'sd5, 4'd9);
    checkOutput("t2_valid", 64'(o_det_valid), 64'd1);
    checkOutput("t2_value", 64'(o_det_value), 64'h1FF_FFFF_FFFB);
    checkOutput("t2_seq", 64'(o_det_seq), 64'd9);
    checkOutput("t2_time", 64'(o_det_time), 64'd4);
    checkOutput("t2_holdoff", 64'(o_state), 64'd3);
    waitArmed("t2_rearm", strobes);
    checkOutput("t2_holdoff_strobes", 64'(strobes), 64'd3);

    applyStimulus(0, 1, 0, 0, 1, 1, 41'd11, 4'd2);
    checkOutput("t3_ack_value", 64'(o_det_value), 64'd11);
    checkOutput("t3_ack_time", 64'(o_det_time), 64'd7);
    checkOutput("t3_ack_overrun", 64'(o_overrun), 64'd0);
    waitArmed("t3_rearm", strobes);
    checkOutput("t3_holdoff_strobes", 64'(strobes), 64'd3);
    applyStimulus(0, 1, 0, 0, 1, 0, 41'd99, 4'd5);
    checkOutput("t3_overrun", 64'(o_overrun), 64'd1);
    checkOutput("t3_kept_value", 64'(o_det_value), 64'd11);
    checkOutput("t3_kept_seq", 64'(o_det_seq), 64'd2);

    applyStimulus(0, 1, 0, 0, 1, 1, 41'd123, 4'd6);
    checkOutput("t4_holdoff_value", 64'(o_det_value), 64'd11);
    checkOutput("t4_holdoff_valid", 64'(o_det_valid), 64'd0);
    waitArmed("t4_rearm", strobes);

    applyStimulus(0, 1, 1, 1, 0, 0, 41'd0, 4'd0);
    checkOutput("t5_idle", 64'(o_state), 64'd0);
    checkOutput("t5_chain", 64'(o_chain_en), 64'd0);
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      stepIdle();
      if (o_sample_strobe) strobes++;
    end
    checkOutput("t5_no_strobes", 64'(strobes), 64'd0);
    checkOutput("t5_time_held", 64'(o_current_time), 64'd13);
    checkOutput("t5_overrun_kept", 64'(o_overrun), 64'd1);

    applyStimulus(0, 1, 1, 0, 0, 0, 41'd0, 4'd0);
    checkOutput("t6_overrun_clr", 64'(o_overrun), 64'd0);
    checkOutput("t6_time_clr", 64'(o_current_time), 64'd0);
    applyStimulus(0, 1, 0, 0, 1, 0, 41'd77, 4'd7);
    checkOutput("t6_warmup_value", 64'(o_det_value), 64'd11);
    stepIdle(); stepIdle();
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 0, 0, 0, 41'd0, 4'd0);
    first_strobe = 0;
    for (int c = 9; c < 40 && first_strobe == 0; c++) begin
      stepIdle();
      if (o_sample_strobe) first_strobe = c;
    end
    checkOutput("t6_shifted_strobe", 64'(first_strobe), 64'd13);

    for (int c = 0; c < 1500; c++) begin
      applyStimulus(0, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, 41'({$urandom(), $urandom()}),
                    4'($urandom()));
    end

    wrap_run = 1; wrap_clear = 1;
    stepIdle();
    wrap_clear = 0;
    wrap_count = 0;
    n = 0;
    while (wrap_count < 255 && n < 2000) begin
      stepIdle();
      n++;
      if (wrap_strobe) wrap_count++;
    end
    checkOutput("wrap_max", 64'(wrap_time), 64'hFF);
    n = 0;
    do begin
      stepIdle();
      n++;
    end while (!wrap_strobe && n < 10);
    checkOutput("wrap_strobe_seen", 64'(wrap_strobe), 64'd1);
    checkOutput("wrap_zero", 64'(wrap_time), 64'h00);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule
